hazard_scheduler: RTL and testbench

Pipeline sequencer for the 5-stage IF/ID/EX/MEM/WB datapath. It keeps a small scoreboard of in-flight destination registers and detects RAW hazards against the instruction in ID. It generates stall (PC/IF-ID hold plus bubble insertion) and flush controls, and redirects the PC on a taken branch resolved at the MEM stage. Sits beside buffer1..buffer4 and drives their write/flush enables and the PCSrc mux select.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_scheduler_if.sv | 52 +++++
 rtl/sat_counter.sv | 21 ++
 rtl/hazard_scheduler.sv | 120 ++++++++++++
 tb/tb_hazard_scheduler.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the hazard scheduler
// Purpose: scoreboard slot type, forwarding-select encoding and the slot/register
//          compare used by the RAW hazard checks.
// Ports:   none (package).
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] dest;
    logic                  is_load;
  } slot_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b10,
    FWD_MEMWB = 2'b01
  } fwd_sel_t;

  // Register $0 is hard-wired, so it never creates a dependency.
  function automatic logic slot_match(input logic v,
                                      input logic [REG_AW_DEF-1:0] d,
                                      input logic [REG_AW_DEF-1:0] r);
    return v && (r != '0) && (d == r);
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// rtl/hazard_scheduler_if.sv - ID/MEM stage inputs and pipeline control outputs
// Purpose: bundles the decode-stage operand fields, the MEM-stage branch status and
//          the stall/flush/PC controls. HAZARD_FORWARDING_EN adds fwd_a/fwd_b.
// Ports:   master = pipeline side (drives id_*/mem_*), slave = scheduler side.
interface hazard_scheduler_if import hazard_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rt_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_regdst;
  logic              id_regwrite;
  logic              id_memread;
  logic              mem_branch;
  logic              mem_zf;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_flush;
  logic              exmem_flush;
  logic              pc_sel_branch;
`ifdef HAZARD_FORWARDING_EN
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output id_valid, id_rs, id_rt, id_rt_used, id_rd, id_regdst, id_regwrite,
           id_memread, mem_branch, mem_zf,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pc_sel_branch,
           fwd_a, fwd_b
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_rt_used, id_rd, id_regdst, id_regwrite,
           id_memread, mem_branch, mem_zf,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pc_sel_branch,
           fwd_a, fwd_b
  );
`else
  modport master (
    output id_valid, id_rs, id_rt, id_rt_used, id_rd, id_regdst, id_regwrite,
           id_memread, mem_branch, mem_zf,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pc_sel_branch
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_rt_used, id_rd, id_regdst, id_regwrite,
           id_memread, mem_branch, mem_zf,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pc_sel_branch
  );
`endif
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
// Purpose: counts cycles with inc=1, holds at all-ones instead of wrapping.
// Ports:   clk, rst_n (async active-low), inc, count[CNT_W-1:0].
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - RAW hazard detection, stall/flush and branch redirect
// Purpose: two-slot scoreboard (EX, MEM) of in-flight destinations checked against
//          the ID operands; produces PC/IF-ID hold, bubble insertion, taken-branch
//          flushes and PCSrc select, plus saturating stall/flush statistics.
//          Optional macro HAZARD_FORWARDING_EN: stall only on load-use and drive
//          registered forwarding selects fwd_a/fwd_b on the interface.
// Ports:   clk, rst_n (async active-low), bus (hazard_scheduler_if.slave),
//          stall_count, flush_count [CNT_W-1:0].
module hazard_scheduler import hazard_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scheduler_if.slave  bus,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);

  slot_t             ex_slot;
  slot_t             mem_slot;
  slot_t             id_entry;
  logic [REG_AW-1:0] id_dest;
  logic              raw_ex;
  logic              raw_mem;
  logic              take;
  logic              stall;
  logic              unused_bits;

  assign id_dest = bus.id_regdst ? bus.id_rd : bus.id_rt;

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = bus.id_valid && bus.id_regwrite && (id_dest != '0);
    id_entry.dest    = id_dest;
    id_entry.is_load = bus.id_memread;
  end

  // WB producers are absent on purpose: the register file writes before ID reads.
  assign raw_ex  = bus.id_valid &&
                   (slot_match(ex_slot.valid, ex_slot.dest, bus.id_rs) ||
                    (bus.id_rt_used && slot_match(ex_slot.valid, ex_slot.dest, bus.id_rt)));
  assign raw_mem = bus.id_valid &&
                   (slot_match(mem_slot.valid, mem_slot.dest, bus.id_rs) ||
                    (bus.id_rt_used && slot_match(mem_slot.valid, mem_slot.dest, bus.id_rt)));

  assign take = bus.mem_branch && bus.mem_zf;

  // A taken branch kills the stalled instruction anyway, so flush wins.
`ifdef HAZARD_FORWARDING_EN
  assign stall = !take && raw_ex && ex_slot.is_load;
  assign unused_bits = mem_slot.is_load ^ raw_mem;
`else
  assign stall = !take && (raw_ex || raw_mem);
  assign unused_bits = mem_slot.is_load;
`endif

  assign bus.pc_write      = !stall;
  assign bus.ifid_write    = !stall;
  assign bus.ifid_flush    = take;
  assign bus.idex_flush    = take || stall;
  assign bus.exmem_flush   = take;
  assign bus.pc_sel_branch = take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else begin
      mem_slot <= take ? '0 : ex_slot;
      ex_slot  <= (take || stall) ? '0 : id_entry;
    end
  end

`ifdef HAZARD_FORWARDING_EN
  fwd_sel_t fwd_a_q;
  fwd_sel_t fwd_b_q;

  // Youngest producer (EX) holds the newest value, so it is checked first.
  function automatic fwd_sel_t fwd_pick(input logic [REG_AW-1:0] r);
    if (slot_match(ex_slot.valid, ex_slot.dest, r))
      return FWD_EXMEM;
    else if (slot_match(mem_slot.valid, mem_slot.dest, r))
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (take || stall || !bus.id_valid) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_pick(bus.id_rs);
      fwd_b_q <= bus.id_rt_used ? fwd_pick(bus.id_rt) : FWD_RF;
    end
  end

  assign bus.fwd_a = fwd_a_q;
  assign bus.fwd_b = fwd_b_q;
`endif

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (take),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - self-checking bench for hazard_scheduler
module tb_hazard_scheduler;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  int tests = 0;
  int errors = 0;

  // Model: destination register of the producer 1 and 2 instructions ahead of ID
  // (0 = none, since $0 never counts as a dependency).
  int m_ahead1, m_ahead2;
  bit m_ahead1_load;
  int m_stalls, m_flushes;
  int m_fa, m_fb;

  always #5 clk = ~clk;

  hazard_scheduler_if #(.REG_AW(5)) bus ();

  hazard_scheduler #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit depends(input int r, input int d);
    return (r != 0) && (r == d);
  endfunction

  function automatic int fwd_for(input int r);
    if (depends(r, m_ahead1)) return 2;
    if (depends(r, m_ahead2)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_ahead1 = 0; m_ahead2 = 0; m_ahead1_load = 0;
    m_stalls = 0; m_flushes = 0; m_fa = 0; m_fb = 0;
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input bit rt_used,
                        input int rd, input bit regdst, input bit rw, input bit mr);
    bus.id_valid    = v;
    bus.id_rs       = 5'(rs);
    bus.id_rt       = 5'(rt);
    bus.id_rt_used  = rt_used;
    bus.id_rd       = 5'(rd);
    bus.id_regdst   = regdst;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle and advances one clock.
  task automatic run_cycle(output bit stalled);
    bit take, hz1, hz2, stall;
    int rs, rt, dest;
    #3;
    rs   = int'(bus.id_rs);
    rt   = int'(bus.id_rt);
    dest = bus.id_regdst ? int'(bus.id_rd) : int'(bus.id_rt);
    take = bus.mem_branch && bus.mem_zf;
    hz1  = bus.id_valid && (depends(rs, m_ahead1) || (bus.id_rt_used && depends(rt, m_ahead1)));
    hz2  = bus.id_valid && (depends(rs, m_ahead2) || (bus.id_rt_used && depends(rt, m_ahead2)));
`ifdef HAZARD_FORWARDING_EN
    stall = !take && hz1 && m_ahead1_load;
`else
    stall = !take && (hz1 || hz2);
`endif
    check("pc_write",      32'(bus.pc_write),      32'(!stall));
    check("ifid_write",    32'(bus.ifid_write),    32'(!stall));
    check("ifid_flush",    32'(bus.ifid_flush),    32'(take));
    check("idex_flush",    32'(bus.idex_flush),    32'(take || stall));
    check("exmem_flush",   32'(bus.exmem_flush),   32'(take));
    check("pc_sel_branch", 32'(bus.pc_sel_branch), 32'(take));
    check("stall_count",   32'(stall_count),       32'(m_stalls));
    check("flush_count",   32'(flush_count),       32'(m_flushes));
`ifdef HAZARD_FORWARDING_EN
    check("fwd_a", 32'(bus.fwd_a), 32'(m_fa));
    check("fwd_b", 32'(bus.fwd_b), 32'(m_fb));
`endif
    if (stall && m_stalls < CNT_MAX) m_stalls++;
    if (take && m_flushes < CNT_MAX) m_flushes++;
    if (take || stall || !bus.id_valid) begin
      m_fa = 0; m_fb = 0;
    end else begin
      m_fa = fwd_for(rs);
      m_fb = bus.id_rt_used ? fwd_for(rt) : 0;
    end
    m_ahead2 = take ? 0 : m_ahead1;
    if (take || stall || !bus.id_valid || !bus.id_regwrite) m_ahead1 = 0;
    else m_ahead1 = dest;
    m_ahead1_load = bus.id_memread;
    stalled = stall;
    @(posedge clk);
    #1;
  endtask

  // Holds the current ID instruction until it leaves ID (bounded); returns stall cycles.
  task automatic issue(output int stalls);
    bit st;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle(st);
      if (!st) return;
      stalls++;
    end
    check("issue_bound", 32'(stalls), 32'd0);
  endtask

  initial begin
    int n;
    bit st;
    model_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.mem_branch = 0;
    bus.mem_zf     = 0;
    #1;
    check("rst_pc_write",   32'(bus.pc_write),   32'd1);
    check("rst_idex_flush", 32'(bus.idex_flush), 32'd0);
    check("rst_stall_cnt",  32'(stall_count),    32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // independent stream
    set_id(1, 1, 2, 1, 1, 1, 1, 0); issue(n); check("ind_1", 32'(n), 0);
    set_id(1, 3, 4, 1, 2, 1, 1, 0); issue(n); check("ind_2", 32'(n), 0);
    set_id(1, 6, 7, 1, 5, 1, 1, 0); issue(n); check("ind_3", 32'(n), 0);

    // producer one ahead
    set_id(1, 1, 2, 1, 3, 1, 1, 0); issue(n);
    set_id(1, 3, 1, 1, 4, 1, 1, 0); issue(n);
`ifdef HAZARD_FORWARDING_EN
    check("dist1_stalls", 32'(n), 0);
    check("dist1_fwd_a", 32'(bus.fwd_a), 32'd2);
`else
    check("dist1_stalls", 32'(n), 2);
`endif

    // producer two ahead
    set_id(1, 1, 2, 1, 3, 1, 1, 0); issue(n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0); issue(n);
    set_id(1, 3, 0, 1, 6, 1, 1, 0); issue(n);
`ifdef HAZARD_FORWARDING_EN
    check("dist2_stalls", 32'(n), 0);
`else
    check("dist2_stalls", 32'(n), 1);
`endif

    // write $0 then read $0
    set_id(1, 1, 0, 0, 0, 0, 1, 0); issue(n);
    set_id(1, 0, 0, 1, 7, 1, 1, 0); issue(n); check("zero_reg", 32'(n), 0);

    // load-use
    set_id(1, 1, 4, 0, 0, 0, 1, 1); issue(n);
    set_id(1, 4, 4, 1, 5, 1, 1, 0); issue(n);
`ifdef HAZARD_FORWARDING_EN
    check("load_use", 32'(n), 1);
`else
    check("load_use", 32'(n), 2);
`endif

    // taken branch with a pending RAW
    set_id(1, 1, 2, 1, 3, 1, 1, 0); issue(n);
    set_id(1, 3, 1, 1, 4, 1, 1, 0);
    bus.mem_branch = 1; bus.mem_zf = 1;
    run_cycle(st); check("take_no_stall", 32'(st), 0);
    bus.mem_branch = 0; bus.mem_zf = 0;
    issue(n); check("after_take", 32'(n), 0);

    // reset in the middle of a stall
    set_id(1, 1, 2, 1, 3, 1, 1, 0); issue(n);
    set_id(1, 3, 1, 1, 4, 1, 1, 0);
    run_cycle(st);
    rst_n = 0;
    #1;
    check("midrst_pc_write",   32'(bus.pc_write),   32'd1);
    check("midrst_idex_flush", 32'(bus.idex_flush), 32'd0);
    check("midrst_stall_cnt",  32'(stall_count),    32'd0);
    check("midrst_flush_cnt",  32'(flush_count),    32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    issue(n); check("post_rst", 32'(n), 0);

    // randomized stream, small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      bit v, rw, mr, rtu, rdst;
      v    = ($urandom_range(0, 99) < 85);
      rw   = ($urandom_range(0, 99) < 70);
      mr   = rw && ($urandom_range(0, 99) < 30);
      rtu  = $urandom_range(0, 1);
      rdst = $urandom_range(0, 1);
      set_id(v, $urandom_range(0, 3), $urandom_range(0, 3), rtu,
             $urandom_range(0, 3), rdst, rw, mr);
      for (int k = 0; k < 8; k++) begin
        bus.mem_branch = ($urandom_range(0, 99) < 15);
        bus.mem_zf     = ($urandom_range(0, 99) < 60);
        run_cycle(st);
        if (!st) break;
      end
    end
    bus.mem_branch = 0; bus.mem_zf = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle(st);
    check("final_stall_cnt", 32'(stall_count), 32'(m_stalls));
    check("final_flush_cnt", 32'(flush_count), 32'(m_flushes));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
